// File: rtl/mips_pkg.sv
// Shared definitions for the mips_pipe core: opcodes, instruction classes, FSM states,
// forwarding selects and instruction-field helpers.
package mips_pkg;

  localparam logic [5:0] OpAdd   = 6'h00;
  localparam logic [5:0] OpSub   = 6'h01;
  localparam logic [5:0] OpAnd   = 6'h02;
  localparam logic [5:0] OpOr    = 6'h03;
  localparam logic [5:0] OpSlt   = 6'h04;
  localparam logic [5:0] OpMul   = 6'h05;
  localparam logic [5:0] OpLw    = 6'h08;
  localparam logic [5:0] OpSw    = 6'h09;
  localparam logic [5:0] OpAddi  = 6'h0A;
  localparam logic [5:0] OpSubi  = 6'h0B;
  localparam logic [5:0] OpSlti  = 6'h0C;
  localparam logic [5:0] OpBneqz = 6'h0D;
  localparam logic [5:0] OpBeqz  = 6'h0E;
  localparam logic [5:0] OpHlt   = 6'h3F;

  typedef enum logic [2:0] {
    ClsRrAlu, ClsRmAlu, ClsLoad, ClsStore, ClsBranch, ClsHalt
  } instr_cls_e;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  typedef enum logic [1:0] {FwdNone, FwdExMem, FwdMemWb} fwd_sel_e;

  function automatic logic [5:0] f_op(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] ir);
    return ir[15:0];
  endfunction

  // Unknown opcodes fall into the halt class so stray data stops the core.
  function automatic instr_cls_e decode_cls(input logic [5:0] op);
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul: return ClsRrAlu;
      OpAddi, OpSubi, OpSlti:                  return ClsRmAlu;
      OpLw:                                    return ClsLoad;
      OpSw:                                    return ClsStore;
      OpBneqz, OpBeqz:                         return ClsBranch;
      default:                                 return ClsHalt;
    endcase
  endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// Stall, flush and operand-forward selection for mips_pipe.
// MIPS_FWD_EN selects EX/MEM and MEM/WB forwarding; otherwise ID stalls on any EX/MEM RAW.
module mips_hazard_unit
  import mips_pkg::*;
(
  input  logic     [4:0] id_rs,
  input  logic     [4:0] id_rt,
  input  logic           id_use_rs,
  input  logic           id_use_rt,
  input  logic           ex_valid,
  input  logic           ex_wr,
  input  logic           ex_load,
  input  logic     [4:0] ex_dest,
  input  logic     [4:0] ex_rs,
  input  logic     [4:0] ex_rt,
  input  logic           mem_valid,
  input  logic           mem_wr,
  input  logic     [4:0] mem_dest,
  input  logic           wb_valid,
  input  logic           wb_wr,
  input  logic     [4:0] wb_dest,
  input  logic           branch_taken,
  input  logic           halt_kill,
  output logic           stall,
  output logic           flush,
  output fwd_sel_e       fwd_a,
  output fwd_sel_e       fwd_b
);

  // wr flags already exclude R0 destinations
  logic ex_hit;
  assign ex_hit = ex_valid && ex_wr &&
                  ((id_use_rs && ex_dest == id_rs) || (id_use_rt && ex_dest == id_rt));

`ifdef MIPS_FWD_EN
  assign stall = ex_hit && ex_load;

  always_comb begin
    fwd_a = FwdNone;
    fwd_b = FwdNone;
    if (mem_valid && mem_wr && mem_dest == ex_rs)   fwd_a = FwdExMem;
    else if (wb_valid && wb_wr && wb_dest == ex_rs) fwd_a = FwdMemWb;
    if (mem_valid && mem_wr && mem_dest == ex_rt)   fwd_b = FwdExMem;
    else if (wb_valid && wb_wr && wb_dest == ex_rt) fwd_b = FwdMemWb;
  end
`else
  logic mem_hit;
  assign mem_hit = mem_valid && mem_wr &&
                   ((id_use_rs && mem_dest == id_rs) || (id_use_rt && mem_dest == id_rt));
  // MEM/WB needs no stall: the register file writes through to ID
  assign stall = ex_hit || mem_hit;
  assign fwd_a = FwdNone;
  assign fwd_b = FwdNone;

  logic unused_nofwd;
  assign unused_nofwd = ^{ex_load, ex_rs, ex_rt, wb_valid, wb_wr, wb_dest};
`endif

  assign flush = branch_taken || halt_kill;

endmodule

// File: rtl/mips_pipe.sv
// Five-stage in-order MIPS32 teaching core with run/halt FSM, load and debug ports.
// Optional forwarding via MIPS_FWD_EN (see mips_hazard_unit).
module mips_pipe
  import mips_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic [4:0]    dbg_raddr,
  input  logic [AW-1:0] dbg_maddr,
  output logic [DW-1:0] dbg_rdata,
  output logic [DW-1:0] dbg_mdata,
  output logic          busy,
  output logic          halted,
  output logic [31:0]   retired
);

  logic [DW-1:0] mem  [MEM_DEPTH];
  logic [DW-1:0] regs [32];

  state_e        state;
  logic [AW-1:0] pc;
  logic          run;

  logic          ifid_valid;
  logic [31:0]   ifid_ir;
  logic [AW-1:0] ifid_pc;

  logic          idex_valid, idex_wr;
  instr_cls_e    idex_cls;
  logic [5:0]    idex_op;
  logic [DW-1:0] idex_a, idex_b, idex_imm;
  logic [4:0]    idex_rs, idex_rt, idex_dest;
  logic [AW-1:0] idex_pc;

  logic          exmem_valid, exmem_wr;
  instr_cls_e    exmem_cls;
  logic [DW-1:0] exmem_alu, exmem_b;
  logic [4:0]    exmem_dest;

  logic          memwb_valid, memwb_wr;
  instr_cls_e    memwb_cls;
  logic [DW-1:0] memwb_res;
  logic [4:0]    memwb_dest;

  assign run = (state == StRun);

  // IF
  logic [AW-1:0] pc_inc;
  logic [31:0]   if_ir;
  assign pc_inc = (pc == AW'(MEM_DEPTH - 1)) ? '0 : pc + AW'(1);
  assign if_ir  = 32'(mem[pc]);

  // ID
  instr_cls_e    id_cls;
  logic [4:0]    id_rs, id_rt, id_dest;
  logic          id_wr;
  logic [DW-1:0] id_a, id_b, id_imm;
  logic          wb_we;

  assign id_cls  = decode_cls(f_op(ifid_ir));
  assign id_rs   = f_rs(ifid_ir);
  assign id_rt   = f_rt(ifid_ir);
  assign id_dest = (id_cls == ClsRrAlu) ? f_rd(ifid_ir) : id_rt;
  assign id_wr   = (id_cls == ClsRrAlu || id_cls == ClsRmAlu || id_cls == ClsLoad) &&
                   (id_dest != 5'd0);
  assign id_imm  = DW'($signed(f_imm(ifid_ir)));
  assign wb_we   = run && memwb_valid && memwb_wr;

  always_comb begin
    id_a = regs[id_rs];
    id_b = regs[id_rt];
    if (id_rs == 5'd0)                          id_a = '0;
    else if (wb_we && memwb_dest == id_rs)      id_a = memwb_res;
    if (id_rt == 5'd0)                          id_b = '0;
    else if (wb_we && memwb_dest == id_rt)      id_b = memwb_res;
  end

  // EX
  fwd_sel_e      fwd_a, fwd_b;
  logic [DW-1:0] ex_a, ex_b, ex_opnd2, ex_alu;
  logic          ex_taken, halt_kill, stall, flush;
  logic [AW-1:0] ex_target;

  always_comb begin
    unique case (fwd_a)
      FwdExMem: ex_a = exmem_alu;
      FwdMemWb: ex_a = memwb_res;
      default:  ex_a = idex_a;
    endcase
    unique case (fwd_b)
      FwdExMem: ex_b = exmem_alu;
      FwdMemWb: ex_b = memwb_res;
      default:  ex_b = idex_b;
    endcase
  end

  assign ex_opnd2 = (idex_cls == ClsRrAlu) ? ex_b : idex_imm;

  always_comb begin
    case (idex_op)
      OpAdd, OpAddi, OpLw, OpSw: ex_alu = ex_a + ex_opnd2;
      OpSub, OpSubi:             ex_alu = ex_a - ex_opnd2;
      OpAnd:                     ex_alu = ex_a & ex_opnd2;
      OpOr:                      ex_alu = ex_a | ex_opnd2;
      OpSlt, OpSlti:             ex_alu = DW'(ex_a < ex_opnd2);
      OpMul:                     ex_alu = ex_a * ex_opnd2;
      default:                   ex_alu = '0;
    endcase
  end

  assign ex_taken  = idex_valid && (idex_cls == ClsBranch) &&
                     ((idex_op == OpBeqz) == (ex_a == '0));
  assign ex_target = idex_pc + AW'(1) + idex_imm[AW-1:0];

  // Once HLT reaches EX nothing younger may progress, so keep the front end drained.
  assign halt_kill = (idex_valid && idex_cls == ClsHalt) ||
                     (exmem_valid && exmem_cls == ClsHalt) ||
                     (memwb_valid && memwb_cls == ClsHalt);

  mips_hazard_unit u_hazard (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (ifid_valid && id_cls != ClsHalt),
    .id_use_rt    (ifid_valid && (id_cls == ClsRrAlu || id_cls == ClsStore)),
    .ex_valid     (idex_valid),
    .ex_wr        (idex_wr),
    .ex_load      (idex_cls == ClsLoad),
    .ex_dest      (idex_dest),
    .ex_rs        (idex_rs),
    .ex_rt        (idex_rt),
    .mem_valid    (exmem_valid),
    .mem_wr       (exmem_wr),
    .mem_dest     (exmem_dest),
    .wb_valid     (memwb_valid),
    .wb_wr        (memwb_wr),
    .wb_dest      (memwb_dest),
    .branch_taken (ex_taken),
    .halt_kill    (halt_kill),
    .stall        (stall),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  // MEM
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_res;
  logic          st_we, ld_ok;

  assign mem_addr = exmem_alu[AW-1:0];
  assign mem_res  = (exmem_cls == ClsLoad) ? mem[mem_addr] : exmem_alu;
  assign st_we    = run && exmem_valid && (exmem_cls == ClsStore);
  assign ld_ok    = ld_we && !run;

  always_ff @(posedge clk) begin
    if (st_we)      mem[mem_addr] <= exmem_b;
    else if (ld_ok) mem[ld_addr]  <= ld_wdata;
  end

  always_ff @(posedge clk) begin
    if (wb_we) regs[memwb_dest] <= memwb_res;
  end

  // Control state and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      pc          <= '0;
      retired     <= '0;
      ifid_valid  <= 1'b0;
      idex_valid  <= 1'b0;
      exmem_valid <= 1'b0;
      memwb_valid <= 1'b0;
    end else begin
      case (state)
        StIdle, StHalted: begin
          if (start) begin
            state       <= StRun;
            pc          <= '0;
            retired     <= '0;
            ifid_valid  <= 1'b0;
            idex_valid  <= 1'b0;
            exmem_valid <= 1'b0;
            memwb_valid <= 1'b0;
          end
        end
        StRun: begin
          if (memwb_valid)                         retired <= retired + 32'd1;
          if (memwb_valid && memwb_cls == ClsHalt) state   <= StHalted;
          memwb_valid <= exmem_valid;
          exmem_valid <= idex_valid;
          if (flush) begin
            idex_valid <= 1'b0;
            ifid_valid <= 1'b0;
            if (ex_taken) pc <= ex_target;
          end else if (stall) begin
            idex_valid <= 1'b0;
          end else begin
            idex_valid <= ifid_valid;
            ifid_valid <= 1'b1;
            pc         <= pc_inc;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Payload registers: contents are don't-care whenever the matching valid bit is low.
  always_ff @(posedge clk) begin
    if (run) begin
      if (!stall) begin
        ifid_ir <= if_ir;
        ifid_pc <= pc;
      end
      idex_cls   <= id_cls;
      idex_op    <= f_op(ifid_ir);
      idex_a     <= id_a;
      idex_b     <= id_b;
      idex_imm   <= id_imm;
      idex_rs    <= id_rs;
      idex_rt    <= id_rt;
      idex_dest  <= id_dest;
      idex_wr    <= id_wr;
      idex_pc    <= ifid_pc;
      exmem_cls  <= idex_cls;
      exmem_alu  <= ex_alu;
      exmem_b    <= ex_b;
      exmem_dest <= idex_dest;
      exmem_wr   <= idex_wr;
      memwb_cls  <= exmem_cls;
      memwb_res  <= mem_res;
      memwb_dest <= exmem_dest;
      memwb_wr   <= exmem_wr;
    end
  end

  assign busy      = run;
  assign halted    = (state == StHalted);
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];
  assign dbg_mdata = mem[dbg_maddr];

endmodule

// File: tb/tb_mips_pipe.sv
// Directed self-checking bench for mips_pipe: small hand-assembled programs, results read
// through the debug ports, cycle counts measured from the start edge to halted.
module tb_mips_pipe;

  localparam int AW = 10;
`ifdef MIPS_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_wdata = '0;
  logic [4:0]    dbg_raddr = '0;
  logic [AW-1:0] dbg_maddr = '0;
  logic [31:0]   dbg_rdata, dbg_mdata, retired;
  logic          busy, halted;

  int checks = 0;
  int errors = 0;

  mips_pipe #(.DW(32), .MEM_DEPTH(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .dbg_raddr (dbg_raddr),
    .dbg_maddr (dbg_maddr),
    .dbg_rdata (dbg_rdata),
    .dbg_mdata (dbg_mdata),
    .busy      (busy),
    .halted    (halted),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  localparam logic [31:0] Hlt = 32'hFC00_0000;

  task automatic ld(input int a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = AW'(a); ld_wdata = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic peek_reg(input int r, output logic [31:0] v);
    dbg_raddr = 5'(r); #1; v = dbg_rdata;
  endtask

  task automatic peek_mem(input int a, output logic [31:0] v);
    dbg_maddr = AW'(a); #1; v = dbg_mdata;
  endtask

  // cyc = edges after the start edge up to and including the one that raises halted
  task automatic run(output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load_fact;
    ld(200, 32'd10);
    ld(198, 32'd0);
    ld(0, enc_i(8'h08, 0, 10, 200));
    ld(1, enc_i(8'h0A, 0, 2, 1));
    ld(2, enc_r(8'h05, 2, 10, 2));
    ld(3, enc_i(8'h0B, 10, 10, 1));
    ld(4, enc_i(8'h0D, 10, 0, -3));
    ld(5, enc_i(8'h09, 0, 2, 198));
    ld(6, Hlt);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL rst_retired got %0d want 0", retired); end
    peek_reg(0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_r0 got %0d want 0", v); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    int cyc;
    ld(0, enc_i(8'h0A, 0, 1, 5));
    ld(1, enc_r(8'h00, 1, 1, 2));
    ld(2, enc_r(8'h01, 2, 1, 3));
    ld(3, Hlt);
    run(cyc);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL b2b_halted got %b want 1", halted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", busy); end
    peek_reg(2, v);
    checks++; if (v !== 32'd10) begin errors++; $display("FAIL b2b_r2 got %0d want 10", v); end
    peek_reg(3, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL b2b_r3 got %0d want 5", v); end
    checks++;
    if (retired !== 32'd4) begin errors++; $display("FAIL b2b_retired got %0d want 4", retired); end
    checks++;
    if (cyc != (Fwd ? 8 : 12)) begin
      errors++; $display("FAIL b2b_cycles got %0d want %0d", cyc, Fwd ? 8 : 12);
    end
  endtask

  task automatic test_load_use;
    logic [31:0] v;
    int cyc;
    ld(120, 32'd85);
    ld(0, enc_i(8'h08, 0, 2, 120));
    ld(1, enc_i(8'h0A, 2, 3, 45));
    ld(2, Hlt);
    run(cyc);
    peek_reg(3, v);
    checks++; if (v !== 32'd130) begin errors++; $display("FAIL lu_r3 got %0d want 130", v); end
    checks++;
    if (retired !== 32'd3) begin errors++; $display("FAIL lu_retired got %0d want 3", retired); end
    checks++;
    if (cyc != (Fwd ? 8 : 9)) begin
      errors++; $display("FAIL lu_cycles got %0d want %0d", cyc, Fwd ? 8 : 9);
    end
  endtask

  task automatic test_factorial;
    logic [31:0] v;
    int cyc;
    load_fact();
    run(cyc);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL fact_halted got %b want 1", halted); end
    peek_mem(198, v);
    checks++;
    if (v !== 32'd3628800) begin errors++; $display("FAIL fact_mem got %0d want 3628800", v); end
    checks++;
    if (retired !== 32'd34) begin errors++; $display("FAIL fact_retired got %0d want 34", retired); end
    peek_reg(10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL fact_r10 got %0d want 0", v); end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] v;
    int cyc;
    load_fact();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_run got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL mid_retired got %0d want 0", retired); end
    @(negedge clk);
    rst = 1'b0;
    peek_mem(198, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL mid_mem got %0d want 0", v); end
    run(cyc);
    peek_mem(198, v);
    checks++;
    if (v !== 32'd3628800) begin errors++; $display("FAIL rerun_mem got %0d want 3628800", v); end
    checks++;
    if (retired !== 32'd34) begin errors++; $display("FAIL rerun_retired got %0d want 34", retired); end
  endtask

  task automatic test_branch;
    logic [31:0] v;
    int cyc;
    ld(0, enc_i(8'h0A, 0, 5, 0));
    ld(1, enc_i(8'h0E, 0, 0, 2));
    ld(2, enc_i(8'h0A, 0, 5, 1));
    ld(3, enc_i(8'h0A, 0, 5, 2));
    ld(4, enc_i(8'h0A, 0, 6, 9));
    ld(5, Hlt);
    run(cyc);
    peek_reg(5, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL br_r5 got %0d want 0", v); end
    peek_reg(6, v);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL br_r6 got %0d want 9", v); end
    checks++;
    if (retired !== 32'd4) begin errors++; $display("FAIL br_retired got %0d want 4", retired); end
    checks++; if (cyc != 10) begin errors++; $display("FAIL br_cycles got %0d want 10", cyc); end
  endtask

  task automatic test_bad_opcode;
    logic [31:0] v;
    int cyc;
    ld(50, 32'h1234);
    ld(0, enc_i(8'h0A, 0, 4, 7));
    ld(1, 32'hF800_0000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ld_we = 1'b1; ld_addr = AW'(50); ld_wdata = 32'hDEAD;
    repeat (3) @(negedge clk);
    ld_we = 1'b0;
    cyc = 3;
    while (!halted && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    peek_reg(4, v);
    checks++; if (v !== 32'd7) begin errors++; $display("FAIL bad_r4 got %0d want 7", v); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL bad_halted got %b want 1", halted); end
    checks++;
    if (retired !== 32'd2) begin errors++; $display("FAIL bad_retired got %0d want 2", retired); end
    checks++; if (cyc != 6) begin errors++; $display("FAIL bad_cycles got %0d want 6", cyc); end
    peek_mem(50, v);
    checks++; if (v !== 32'h1234) begin errors++; $display("FAIL bad_ldrun got %h want 1234", v); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_factorial();
    test_reset_mid_run();
    test_branch();
    test_bad_opcode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_pipe.md
# mips_pipe

Parametrised successor to the team's two-phase MIPS32 teaching pipeline: a single-clock, five-stage (IF/ID/EX/MEM/WB) in-order core running the same 6-bit-opcode ISA. It adds hardware hazard handling, branch flushing, an explicit run/halt state machine and load/debug ports. The core therefore runs arbitrary programs without dummy instructions, and benches drive it without hierarchical pokes. It sits at the top of the class processor subsystem and owns a unified word-addressed memory.

## Interface
- DW, 32, datapath/register/memory word width (≥16); immediates sign-extend from 16 to DW
- MEM_DEPTH, 1024, memory words; AW = $clog2(MEM_DEPTH)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse in IDLE: begin execution at PC=0
- ld_we  in  1  load-port write enable, honoured only in IDLE/HALTED
- ld_addr  in  AW  load-port word address
- ld_wdata  in  DW  load-port data
- dbg_raddr  in  5  debug register/memory select (reg index)
- dbg_maddr  in  AW  debug memory read address
- dbg_rdata  out  DW  combinational Reg[dbg_raddr] (0 for R0)
- dbg_mdata  out  DW  combinational Mem[dbg_maddr]
- busy  out  1  state == RUN
- halted  out  1  state == HALTED
- retired  out  32  count of committed instructions (HLT included)

## Operation
- Control FSM: IDLE -(start)-> RUN -(HLT in WB)-> HALTED -(start)-> RUN (PC=0, pipeline cleared, retired cleared). start ignored while RUN.
- Opcodes (package): ADD 00, SUB 01, AND 02, OR 03, SLT 04, MUL 05, LW 08, SW 09, ADDI 0A, SUBI 0B, SLTI 0C, BNEQZ 0D, BEQZ 0E, HLT 3F; any other opcode decodes as HLT.
- Field use: rs[25:21], rt[20:16], rd[15:11], imm[15:0]; RR writes rd, RM/LW write rt; R0 reads 0, writes to R0 dropped. MUL keeps low DW bits; SLT/SLTI unsigned compare, result 0/1.
- Addresses: LW/SW effective address = rs+imm truncated to AW (wraps). Branch target = PC_of_branch+1+imm, truncated to AW. PC increments mod MEM_DEPTH.
- Branch resolved in EX; taken -> IF/ID and ID/EX converted to bubbles (no delay slots, no architectural effect from flushed instructions).
- Register file write-through: WB write is visible to ID reads in the same cycle.
- Hazards: RAW on rs/rt against EX/MEM and MEM/WB destinations, R0 excluded. SW data (rt) obeys the same rules.
- HLT: on reaching WB, FSM -> HALTED at that edge; instructions younger than HLT never write Reg/Mem.
- Load port writes Mem only in IDLE/HALTED; ignored while RUN.

## Timing
- Reset values: state IDLE, busy 0, halted 0, retired 0, PC 0, all pipeline valid bits 0 (bubbles), Reg and Mem not reset.
- Instruction fetched at edge N writes Reg at edge N+4; SW writes Mem at edge N+3.
- First fetch on the edge after start is sampled.
- Steady state one retire/cycle; LW followed by dependent instruction: +1 bubble; taken branch: +2 bubbles; not-taken: 0.
- halted rises at the edge HLT commits; retired increments on that same edge.
- rst asserted mid-RUN: immediate return to IDLE, in-flight stores abandoned.

## Configuration
- MIPS_FWD_EN defined: EX/MEM->EX and MEM/WB->EX forwarding (EX/MEM priority); only load-use stalls (1 cycle).
- Undefined: no forwarding muxes; ID stalls while any older in-flight instruction in EX or MEM targets rs/rt. The write-through register file then leaves a maximum 2-bubble stall. Results are identical, cycle counts larger.

## Structure
- mips_pkg: opcode constants, instruction-class enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT), FSM state enum, field-slice helpers.
- Sub-module mips_hazard_unit: stall/flush/forward-select generation from the stage destination fields, rs/rt, and the load/branch flags.

## Test plan
- ADDI R1,R0,5; ADD R2,R1,R1; SUB R3,R2,R1 back-to-back -> R2=10, R3=5. With forwarding: 3 retires in 3 consecutive cycles.
- Mem[120]=85; LW R2,120(R0); ADDI R3,R2,45 -> R3=130, exactly 1 bubble (forwarding build).
- Factorial: Mem[200]=10, loop MUL/SUBI/BNEQZ, SW result to 198 -> Mem[198]=3628800. halted=1; retired equals the static count.
- BEQZ R0,+2 followed by two ADDI to R5 -> R5 unchanged (0), target instruction executes, 2-cycle penalty.
- Unknown opcode 0x3E at Mem[1] after ADDI R4,R0,7 -> R4=7, halted=1, retired=2. ld_we during RUN leaves Mem unchanged.
- rst pulse mid-loop -> busy=0, retired=0 immediately. A following start reruns from PC=0 to the same final state.
